// File: rtl/bus_arbiter_rr_x4_pkg.sv
// Shared types and the round-robin pick helper for the 4-requester bus arbiter.
package bus_arbiter_rr_x4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    // Scans circularly starting at ptr. The lowest circular offset wins,
    // so the loop runs from the farthest offset to the nearest.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [1:0]       ptr);
        logic [N_REQ-1:0] onehot;
        logic [1:0]       idx;
        onehot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                onehot      = '0;
                onehot[idx] = 1'b1;
            end
        end
        return onehot;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [N_REQ-1:0] onehot);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (onehot[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_x4_rr_pick4.sv
// Combinational round-robin picker: one-hot winner among 4 requests, starting at ptr.
module rr_pick4
    import bus_arbiter_rr_x4_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic             any_o
);

    assign onehot_o = rr_pick(req_i, ptr_i);
    assign any_o    = |req_i;

endmodule

// File: rtl/bus_arbiter_rr_x4.sv
// Round-robin owner of a shared operand bus: one switch enabled at a time,
// a dead turnaround cycle between owners, and an optional hold limit per owner.
module bus_arbiter_rr_x4
    import bus_arbiter_rr_x4_pkg::*;
#(
    parameter int unsigned UUID      = 0,
    parameter string       NAME      = "",
    parameter int          BIT_WIDTH = 8,
    parameter int          MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     Req,
    input  logic [BIT_WIDTH-1:0] Input1,
    input  logic [BIT_WIDTH-1:0] Input2,
    input  logic [BIT_WIDTH-1:0] Input3,
    input  logic [BIT_WIDTH-1:0] Input4,
    output logic [N_REQ-1:0]     Grant,
    output logic [N_REQ-1:0]     Enable,
    output logic [BIT_WIDTH-1:0] Output,
    output logic                 Busy
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic              pick_any;
    logic              leave;

    rr_pick4 u_pick (
        .req_i    (Req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .any_o    (pick_any)
    );

    // A dropped request and an expired hold on the same edge are a single leave.
    assign leave = !Req[owner_q] || ((MAX_HOLD > 0) && (hold_q == HOLD_LAST));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, TURNAROUND: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    owner_d = onehot_idx(pick_onehot);
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            GRANT: begin
                if (leave) begin
                    state_d = TURNAROUND;
                    grant_d = '0;
                    ptr_d   = owner_q + 2'd1;
                    hold_d  = '0;
                end else if (MAX_HOLD > 0) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating off the same pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign Grant  = grant_q;
    assign Enable = grant_q;
    assign Busy   = (state_q != IDLE);

    // One switch per requester; at most one is enabled, so OR-combining is safe.
    logic [BIT_WIDTH-1:0] src  [N_REQ];
    logic [BIT_WIDTH-1:0] lane [N_REQ];

    assign src[0] = Input1;
    assign src[1] = Input2;
    assign src[2] = Input3;
    assign src[3] = Input4;

    for (genvar i = 0; i < N_REQ; i++) begin : g_switch
        assign lane[i] = Enable[i] ? src[i] : '0;
    end

    always_comb begin
        Output = '0;
        for (int k = 0; k < N_REQ; k++) begin
            Output = Output | lane[k];
        end
    end

endmodule
